// File: rtl/cmsdk_apb_reset_ctrl_pkg.sv
// Shared definitions for the APB reset controller: register map, bit positions,
// software-reset key and sequencer state encoding.
package cmsdk_apb_reset_ctrl_pkg;

    localparam logic [9:0]  ADDR_RSTINFO = 10'h000;
    localparam logic [9:0]  ADDR_CTRL    = 10'h001;
    localparam logic [9:0]  ADDR_SWRESET = 10'h002;

    localparam int RSTINFO_REQ    = 0;
    localparam int RSTINFO_WDOG   = 1;
    localparam int RSTINFO_LOCKUP = 2;
    localparam int RSTINFO_SW     = 3;

    localparam int CTRL_LOCKUP_EN = 0;
    localparam int CTRL_WDOG_EN   = 1;

    localparam logic [31:0] SWRESET_KEY = 32'h5FA0_0001;
    localparam logic [1:0]  CTRL_RESET  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } rst_state_e;

endpackage

// File: rtl/cmsdk_rstctrl_sync_edge.sv
// Level synchroniser plus registered rising-edge detector; BYPASS skips the
// synchroniser for sources already in the PCLK domain.
module cmsdk_rstctrl_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit BYPASS      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic rise_out
);

    logic level;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    generate
        if (BYPASS) begin : g_bypass
            assign level = d_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q, sync_d;

            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign level = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        prev_d = level;
        rise_d = level & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_out = rise_q;

endmodule

// File: rtl/cmsdk_apb_reset_ctrl.sv
// APB reset controller: stretches watchdog/CPU/software reset requests into SYSRESETn
// and logs the cause. LOCKUP support is built only with CMSDK_RSTCTRL_LOCKUP_RESET_EN.
module cmsdk_apb_reset_ctrl
    import cmsdk_apb_reset_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [11:2] PADDR,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    input  logic        WDOGRES,
    input  logic        SYSRESETREQ,
    input  logic        LOCKUP,
    output logic        SYSRESETn
);

`ifdef CMSDK_RSTCTRL_LOCKUP_RESET_EN
    localparam logic [3:0] RSTINFO_IMPL = 4'b1111;
    localparam logic [1:0] CTRL_IMPL    = 2'b11;
`else
    localparam logic [3:0] RSTINFO_IMPL = 4'b1011;
    localparam logic [1:0] CTRL_IMPL    = 2'b10;
`endif

    localparam logic [7:0] HOLD_LOAD    = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_CYCLES - 1);

    logic        wd_rise, rq_rise, lk_rise;
    logic        wr_setup, rd_setup;
    logic        wd_trig, lk_trig, sw_trig, any_trig;
    logic [3:0]  set_vec, clr_vec;
    logic [3:0]  rstinfo_q, rstinfo_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] prdata_q, prdata_d;
    rst_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sysresetn_q, sysresetn_d;

    cmsdk_rstctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .BYPASS(1'b0)) u_wd_sync (
        .clk(PCLK), .rst_n(PRESETn), .d_in(WDOGRES), .rise_out(wd_rise)
    );

    cmsdk_rstctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .BYPASS(1'b1)) u_rq_sync (
        .clk(PCLK), .rst_n(PRESETn), .d_in(SYSRESETREQ), .rise_out(rq_rise)
    );

`ifdef CMSDK_RSTCTRL_LOCKUP_RESET_EN
    cmsdk_rstctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .BYPASS(1'b0)) u_lk_sync (
        .clk(PCLK), .rst_n(PRESETn), .d_in(LOCKUP), .rise_out(lk_rise)
    );
`else
    logic unused_lockup;
    assign unused_lockup = LOCKUP;
    assign lk_rise       = 1'b0;
`endif

    // Set beats clear on RSTINFO so a cause arriving during a W1C is never lost.
    always_comb begin
        wr_setup = PSEL & PWRITE & ~PENABLE;
        rd_setup = PSEL & ~PWRITE & ~PENABLE;
        wd_trig  = wd_rise & ctrl_q[CTRL_WDOG_EN];
        lk_trig  = lk_rise & ctrl_q[CTRL_LOCKUP_EN];
        sw_trig  = wr_setup && (PADDR == ADDR_SWRESET) && (PWDATA == SWRESET_KEY);

        set_vec                 = '0;
        set_vec[RSTINFO_REQ]    = rq_rise;
        set_vec[RSTINFO_WDOG]   = wd_trig;
        set_vec[RSTINFO_LOCKUP] = lk_trig;
        set_vec[RSTINFO_SW]     = sw_trig;
        any_trig                = |set_vec;

        clr_vec   = (wr_setup && (PADDR == ADDR_RSTINFO)) ? PWDATA[3:0] : 4'h0;
        rstinfo_d = ((rstinfo_q & ~clr_vec) | set_vec) & RSTINFO_IMPL;

        ctrl_d = ctrl_q;
        if (wr_setup && (PADDR == ADDR_CTRL)) begin
            ctrl_d = PWDATA[1:0] & CTRL_IMPL;
        end

        prdata_d = '0;
        if (rd_setup) begin
            case (PADDR)
                ADDR_RSTINFO: prdata_d = {28'h0, rstinfo_q};
                ADDR_CTRL:    prdata_d = {30'h0, ctrl_q};
                default:      prdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_trig) begin
                    state_d = ST_ASSERT;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = HOLDOFF_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        sysresetn_d = (state_d != ST_ASSERT);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rstinfo_q <= '0;
            ctrl_q    <= CTRL_RESET & CTRL_IMPL;
            prdata_q  <= '0;
        end else begin
            rstinfo_q <= rstinfo_d;
            ctrl_q    <= ctrl_d;
            prdata_q  <= prdata_d;
        end
    end

    // Power-on behaves like a reset event: the hold starts counting as soon as PRESETn lifts.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_ASSERT;
            cnt_q       <= HOLD_LOAD;
            sysresetn_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sysresetn_q <= sysresetn_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign SYSRESETn = sysresetn_q;

endmodule

// File: tb/tb_cmsdk_apb_reset_ctrl.sv
// Directed bench for cmsdk_apb_reset_ctrl: table-driven register vectors plus
// multi-cycle reset sequences. Honours CMSDK_RSTCTRL_LOCKUP_RESET_EN.
module tb_cmsdk_apb_reset_ctrl;

    localparam int HOLD    = 16;
    localparam int HOLDOFF = 4;
    localparam int SYNC    = 2;

`ifdef CMSDK_RSTCTRL_LOCKUP_RESET_EN
    localparam logic [31:0] CTRL_MASK = 32'h3;
`else
    localparam logic [31:0] CTRL_MASK = 32'h2;
`endif

    localparam logic [31:0] KEY = 32'h5FA0_0001;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic [11:2] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        WDOGRES;
    logic        SYSRESETREQ;
    logic        LOCKUP;
    logic        SYSRESETn;

    typedef struct {
        logic        wr;
        logic [11:0] off;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_srn;
    } vec_t;

    vec_t vecs[14];

    int n_compared   = 0;
    int n_mismatched = 0;

    int mon_pulses = 0;
    int mon_width  = 0;
    int mon_run    = 0;

    cmsdk_apb_reset_ctrl #(
        .HOLD_CYCLES(HOLD), .HOLDOFF_CYCLES(HOLDOFF), .SYNC_STAGES(SYNC)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .WDOGRES(WDOGRES), .SYSRESETREQ(SYSRESETREQ), .LOCKUP(LOCKUP),
        .SYSRESETn(SYSRESETn)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Measures every completed low pulse of SYSRESETn in negedge samples.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            mon_run <= 0;
        end else if (!SYSRESETn) begin
            mon_run <= mon_run + 1;
        end else if (mon_run != 0) begin
            mon_pulses <= mon_pulses + 1;
            mon_width  <= mon_run;
            mon_run    <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr[11:2]; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr[11:2];
        @(negedge PCLK);
        data = PRDATA;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [31:0] rdata);
        rdata = '0;
        if (v.wr) apb_write(v.off, v.wdata);
        else      apb_read(v.off, rdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wait_pulse(input int base, input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge PCLK);
            if (mon_pulses > base) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        apb_read(addr, rd);
        checkOutput(name, rd, exp);
    endtask

    initial begin
        int   base;
        int   lat;
        bit   got;
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 12'h000, 32'h0,          32'h0,     1'b1};
        vecs[1]  = '{1'b0, 12'h004, 32'h0,          CTRL_MASK, 1'b1};
        vecs[2]  = '{1'b1, 12'h004, 32'h0,          32'h0,     1'b1};
        vecs[3]  = '{1'b0, 12'h004, 32'h0,          32'h0,     1'b1};
        vecs[4]  = '{1'b1, 12'h004, 32'hFFFF_FFFF,  32'h0,     1'b1};
        vecs[5]  = '{1'b0, 12'h004, 32'h0,          CTRL_MASK, 1'b1};
        vecs[6]  = '{1'b0, 12'h008, 32'h0,          32'h0,     1'b1};
        vecs[7]  = '{1'b1, 12'h008, 32'h5FA0_0000,  32'h0,     1'b1};
        vecs[8]  = '{1'b0, 12'h000, 32'h0,          32'h0,     1'b1};
        vecs[9]  = '{1'b1, 12'h00C, 32'hFFFF_FFFF,  32'h0,     1'b1};
        vecs[10] = '{1'b0, 12'h00C, 32'h0,          32'h0,     1'b1};
        vecs[11] = '{1'b0, 12'h004, 32'h0,          CTRL_MASK, 1'b1};
        vecs[12] = '{1'b1, 12'h000, 32'hF,          32'h0,     1'b1};
        vecs[13] = '{1'b0, 12'h000, 32'h0,          32'h0,     1'b1};

        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
        PWDATA = '0; WDOGRES = 1'b0; SYSRESETREQ = 1'b0; LOCKUP = 1'b0;

        $display("[TB] power-on reset");
        idle(3);
        checkOutput("reset_sysresetn", 32'(SYSRESETn), 32'h0);
        checkOutput("reset_prdata", PRDATA, 32'h0);
        base = mon_pulses;
        @(posedge PCLK);
        #2 PRESETn = 1'b1;
        wait_pulse(base, 40, got);
        checkOutput("poweron_pulse_seen", 32'(got), 32'h1);
        checkOutput("poweron_width", 32'(mon_width), 32'(HOLD));
        idle(6);

        $display("[TB] register vectors");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], rd);
            if (!vecs[i].wr) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_sysresetn", i), 32'(SYSRESETn), 32'(vecs[i].exp_srn));
        end
        idle(4);

        $display("[TB] watchdog reset");
        base = mon_pulses;
        WDOGRES = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge PCLK);
            if (!SYSRESETn) begin
                lat = i;
                break;
            end
        end
        checkOutput("wdog_latency", 32'(lat), 32'(SYNC + 2));
        wait_pulse(base, 40, got);
        checkOutput("wdog_pulse_seen", 32'(got), 32'h1);
        checkOutput("wdog_width", 32'(mon_width), 32'(HOLD));
        idle(30);
        checkOutput("wdog_level_single", 32'(mon_pulses), 32'(base + 1));
        read_check("wdog_rstinfo", 12'h000, 32'h2);
        apb_write(12'h000, 32'h2);
        read_check("wdog_rstinfo_cleared", 12'h000, 32'h0);
        WDOGRES = 1'b0;
        idle(4);

        $display("[TB] watchdog masking");
        apb_write(12'h004, 32'h1);
        base = mon_pulses;
        WDOGRES = 1'b1;
        idle(30);
        checkOutput("mask_no_pulse", 32'(mon_pulses), 32'(base));
        read_check("mask_rstinfo", 12'h000, 32'h0);
        WDOGRES = 1'b0;
        idle(4);
        base = mon_pulses;
        SYSRESETREQ = 1'b1;
        wait_pulse(base, 40, got);
        checkOutput("req_pulse_seen", 32'(got), 32'h1);
        checkOutput("req_width", 32'(mon_width), 32'(HOLD));
        read_check("req_rstinfo", 12'h000, 32'h1);
        SYSRESETREQ = 1'b0;
        apb_write(12'h000, 32'hF);
        apb_write(12'h004, 32'h3);
        idle(8);

        $display("[TB] software key");
        base = mon_pulses;
        apb_write(12'h008, 32'h5FA0_0000);
        idle(25);
        checkOutput("swkey_wrong_no_pulse", 32'(mon_pulses), 32'(base));
        read_check("swkey_wrong_rstinfo", 12'h000, 32'h0);
        base = mon_pulses;
        apb_write(12'h008, KEY);
        wait_pulse(base, 40, got);
        checkOutput("swkey_pulse_seen", 32'(got), 32'h1);
        checkOutput("swkey_width", 32'(mon_width), 32'(HOLD));
        read_check("swkey_rstinfo", 12'h000, 32'h8);
        apb_write(12'h000, 32'hF);
        idle(8);

        $display("[TB] overlapping requests");
        base = mon_pulses;
        WDOGRES = 1'b1;
        idle(2);
        SYSRESETREQ = 1'b1;
        idle(6);
        SYSRESETREQ = 1'b0;
        idle(2);
        SYSRESETREQ = 1'b1;
        idle(2);
        SYSRESETREQ = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge PCLK);
            if (SYSRESETn) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("overlap_release_seen", 32'(got), 32'h1);
        SYSRESETREQ = 1'b1;
        idle(2);
        SYSRESETREQ = 1'b0;
        idle(30);
        checkOutput("overlap_single_pulse", 32'(mon_pulses), 32'(base + 1));
        checkOutput("overlap_width", 32'(mon_width), 32'(HOLD));
        read_check("overlap_rstinfo", 12'h000, 32'h3);
        WDOGRES = 1'b0;
        apb_write(12'h000, 32'hF);
        idle(6);

        $display("[TB] set/clear race");
        base = mon_pulses;
        WDOGRES = 1'b1;
        idle(3);
        apb_write(12'h000, 32'h2);
        read_check("race_set_wins", 12'h000, 32'h2);
        wait_pulse(base, 40, got);
        checkOutput("race_pulse_seen", 32'(got), 32'h1);
        WDOGRES = 1'b0;
        apb_write(12'h000, 32'h2);
        read_check("race_cleared", 12'h000, 32'h0);
        idle(6);

        $display("[TB] reset during hold");
        apb_write(12'h004, 32'h0);
        SYSRESETREQ = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            if (!SYSRESETn) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("midreset_pulse_started", 32'(got), 32'h1);
        idle(5);
        #2 PRESETn = 1'b0;
        SYSRESETREQ = 1'b0;
        #1 checkOutput("midreset_sysresetn_low", 32'(SYSRESETn), 32'h0);
        idle(3);
        base = mon_pulses;
        @(posedge PCLK);
        #2 PRESETn = 1'b1;
        wait_pulse(base, 40, got);
        checkOutput("midreset_pulse_seen", 32'(got), 32'h1);
        checkOutput("midreset_width", 32'(mon_width), 32'(HOLD));
        idle(6);
        read_check("midreset_rstinfo", 12'h000, 32'h0);
        read_check("midreset_ctrl", 12'h004, CTRL_MASK);

        $display("[TB] lockup input");
        base = mon_pulses;
        LOCKUP = 1'b1;
        idle(30);
`ifdef CMSDK_RSTCTRL_LOCKUP_RESET_EN
        checkOutput("lockup_pulse", 32'(mon_pulses), 32'(base + 1));
        checkOutput("lockup_width", 32'(mon_width), 32'(HOLD));
        read_check("lockup_rstinfo", 12'h000, 32'h4);
`else
        checkOutput("lockup_ignored", 32'(mon_pulses), 32'(base));
        read_check("lockup_rstinfo", 12'h000, 32'h0);
`endif
        LOCKUP = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: actual running required finished");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule
